// File: rtl/sd_pkg.sv
// Shared definitions for the SD command controller: response types, FSM states,
// CRC7 polynomial and command/response field positions.
package sd_pkg;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_48   = 2'd1;
   localparam logic [1:0] RESP_R2   = 2'd2;
   localparam logic [1:0] RESP_R3   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CRC_TX,
      ST_LOAD,
      ST_WAIT_TX,
      ST_WAIT_RESP,
      ST_CRC_RX,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [6:0]  CRC7_POLY     = 7'h09;
   localparam logic [1:0]  PKT_PREFIX    = 2'b01;
   localparam int unsigned PKT_IDX_HI    = 45;
   localparam int unsigned PKT_IDX_LO    = 40;
   localparam int unsigned PKT_CRC_HI    = 7;
   localparam int unsigned PKT_CRC_LO    = 1;
   localparam int unsigned R2_HDR_HI     = 133;
   localparam int unsigned R2_HDR_LO     = 128;
   localparam logic [5:0]  R2_HDR_VAL    = 6'h3F;
   localparam logic [15:0] CRC_BITS_LAST = 16'd39;

   // One serial CRC7 step, MSB-first shift with feedback into taps x^3 and x^0.
   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one bit per clock; shared between command and response.
module sd_crc7
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic       din,
   output logic [6:0] crc
);

   logic [6:0] crc_q;
   logic [6:0] crc_d;

   always_comb crc_d = crc7_step(crc_q, din);

   always_ff @(posedge clk) begin
      if (reset || clear) crc_q <= '0;
      else if (enable)    crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD command-issue controller: builds the CRC7-protected command, hands it to the
// serializer, collects and validates the response, reports with one done strobe.
module sd_cmd_ctrl
   import sd_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 64,
   parameter int unsigned TX_WDOG      = 128
) (
   input  logic          sd_clk,
   input  logic          reset,
   input  logic          cmd_start,
   input  logic [5:0]    cmd_index,
   input  logic [31:0]   cmd_arg,
   input  logic [1:0]    resp_type,
   output logic          busy,
   output logic          done_strb,
   output logic          timeout_err,
   output logic          crc_err,
   output logic          index_err,
   output logic          end_err,
   output logic [47:0]   resp_out,
   output logic [127:0]  resp2_out,
   output logic          snd_cmd_strb,
   output logic [47:0]   cmd_packet,
   output logic          r2_resp_enb,
   input  logic          end_bit_det_strb,
   input  logic          new_resp_packet_strb,
   input  logic          new_r2_packet_strb,
   input  logic [47:0]   resp_packet,
   input  logic [135:0]  resp2_packet
);

   localparam logic [15:0] TO_LIM = 16'(RESP_TIMEOUT);
   localparam logic [15:0] TX_LIM = 16'(TX_WDOG);

   state_t         state_q;
   logic [15:0]    cnt_q;
   logic [39:0]    sh_q;
   logic [5:0]     idx_q;
   logic [31:0]    arg_q;
   logic [1:0]     type_q;
   logic [5:0]     r2_hdr_q;
   logic           busy_q, done_q, snd_q, r2_enb_q;
   logic           to_err_q, crc_err_q, idx_err_q, end_err_q;
   logic [47:0]    resp_q;
   logic [127:0]   resp2_q;
   logic [47:0]    pkt_q;

   logic [6:0]     crc;
   logic           crc_clear, crc_en;
   logic [15:0]    cnt_inc;
   logic           resp_hit;
   logic           unused_r2_bits;

   // The CRC engine is cleared while idle and while waiting for a response, so
   // both the TX and RX passes start from zero without a dedicated clear state.
   always_comb begin
      crc_clear = (state_q == ST_IDLE) || (state_q == ST_WAIT_RESP);
      crc_en    = (state_q == ST_CRC_TX) || (state_q == ST_CRC_RX);
   end

   assign cnt_inc        = cnt_q + 16'd1;
   assign resp_hit       = (type_q == RESP_R2) ? new_r2_packet_strb : new_resp_packet_strb;
   assign unused_r2_bits = ^resp2_packet[135:134];

   sd_crc7 u_crc7 (
      .clk    (sd_clk),
      .reset  (reset),
      .clear  (crc_clear),
      .enable (crc_en),
      .din    (sh_q[39]),
      .crc    (crc)
   );

   always_ff @(posedge sd_clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sh_q      <= '0;
         idx_q     <= '0;
         arg_q     <= '0;
         type_q    <= RESP_NONE;
         r2_hdr_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         snd_q     <= 1'b0;
         r2_enb_q  <= 1'b0;
         to_err_q  <= 1'b0;
         crc_err_q <= 1'b0;
         idx_err_q <= 1'b0;
         end_err_q <= 1'b0;
         resp_q    <= '0;
         resp2_q   <= '0;
         pkt_q     <= '1;
      end else begin
         done_q <= 1'b0;
         snd_q  <= 1'b0;
         case (state_q)
            ST_IDLE: if (cmd_start) begin
               idx_q     <= cmd_index;
               arg_q     <= cmd_arg;
               type_q    <= resp_type;
               sh_q      <= {PKT_PREFIX, cmd_index, cmd_arg};
               cnt_q     <= '0;
               to_err_q  <= 1'b0;
               crc_err_q <= 1'b0;
               idx_err_q <= 1'b0;
               end_err_q <= 1'b0;
               busy_q    <= 1'b1;
               r2_enb_q  <= (resp_type == RESP_R2);
               state_q   <= ST_CRC_TX;
            end
            ST_CRC_TX, ST_CRC_RX: begin
               sh_q <= {sh_q[38:0], 1'b0};
               if (cnt_q == CRC_BITS_LAST)
                  state_q <= (state_q == ST_CRC_TX) ? ST_LOAD : ST_CHECK;
               else
                  cnt_q <= cnt_inc;
            end
            ST_LOAD: begin
               pkt_q   <= {PKT_PREFIX, idx_q, arg_q, crc, 1'b1};
               snd_q   <= 1'b1;
               cnt_q   <= '0;
               state_q <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               if (end_bit_det_strb) begin
                  cnt_q <= '0;
                  if (type_q == RESP_NONE) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     state_q <= ST_WAIT_RESP;
                  end
               end else if (cnt_inc == TX_LIM) begin
                  to_err_q <= 1'b1;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            ST_WAIT_RESP: begin
               if (resp_hit) begin
                  cnt_q <= '0;
                  if (type_q == RESP_R2) begin
                     resp2_q  <= resp2_packet[127:0];
                     r2_hdr_q <= resp2_packet[R2_HDR_HI:R2_HDR_LO];
                     state_q  <= ST_CHECK;
                  end else begin
                     resp_q  <= resp_packet;
                     sh_q    <= resp_packet[47:8];
                     state_q <= (type_q == RESP_48) ? ST_CRC_RX : ST_CHECK;
                  end
               end else if (cnt_inc == TO_LIM) begin
                  to_err_q <= 1'b1;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            ST_CHECK: begin
               case (type_q)
                  RESP_48: begin
                     crc_err_q <= (crc != resp_q[PKT_CRC_HI:PKT_CRC_LO]);
                     idx_err_q <= (resp_q[PKT_IDX_HI:PKT_IDX_LO] != idx_q);
                     end_err_q <= !resp_q[0];
                  end
                  RESP_R2: begin
                     idx_err_q <= (r2_hdr_q != R2_HDR_VAL);
                     end_err_q <= !resp2_q[0];
                  end
                  RESP_R3: end_err_q <= !resp_q[0];
                  default: ;
               endcase
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               busy_q   <= 1'b0;
               r2_enb_q <= 1'b0;
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign done_strb    = done_q;
   assign snd_cmd_strb = snd_q;
   assign r2_resp_enb  = r2_enb_q;
   assign timeout_err  = to_err_q;
   assign crc_err      = crc_err_q;
   assign index_err    = idx_err_q;
   assign end_err      = end_err_q;
   assign resp_out     = resp_q;
   assign resp2_out    = resp2_q;
   assign cmd_packet   = pkt_q;

endmodule

// File: doc/sd_cmd_ctrl.md
Name: sd_cmd_ctrl

Overview:
- Command-issue controller sitting directly upstream of the SD command serializer/deserializer (`cmd_serial_mod`).
- Accepts a command index, argument and expected response type, then computes CRC7 serially and assembles the 48-bit command packet.
- Strobes the serializer, waits for transmission to finish, then waits for the response or a timeout.
- Validates the response (CRC7, index, end bit) and reports status to the host-side SD state machine with a single done strobe.

Parameters:
- RESP_TIMEOUT, 64, sd_clk cycles allowed after `end_bit_det_strb` before declaring no response (NCR max).
- TX_WDOG, 128, sd_clk cycles allowed between `snd_cmd_strb` and `end_bit_det_strb` before aborting.

Ports:
- sd_clk  in  1  SD clock
- reset  in  1  synchronous, active-high
- cmd_start  in  1  one-cycle request strobe; sampled only in IDLE
- cmd_index  in  6  command index, captured on accepted cmd_start
- cmd_arg  in  32  argument, captured on accepted cmd_start
- resp_type  in  2  0=none, 1=48-bit with CRC (R1/R1b/R6/R7), 2=R2 136-bit, 3=R3 48-bit no CRC
- busy  out  1  high from accepted cmd_start until done_strb inclusive
- done_strb  out  1  one-cycle completion pulse
- timeout_err, crc_err, index_err, end_err  out  1 each  status, valid from done_strb until next accepted cmd_start
- resp_out  out  48  captured 48-bit response
- resp2_out  out  128  captured R2 payload = resp2_packet[127:0]
- snd_cmd_strb  out  1  to serializer, one-cycle pulse
- cmd_packet  out  48  to serializer; held stable from LOAD until DONE
- r2_resp_enb  out  1  to serializer; equals (resp_type==2) for the command in flight, 0 in IDLE
- end_bit_det_strb, new_resp_packet_strb, new_r2_packet_strb  in  1 each  from serializer
- resp_packet  in  48; resp2_packet  in  136  from serializer

Behaviour:
- Interface: reset is `reset`, synchronous, active-high; clock is `sd_clk`.
- Reset values: all outputs 0; state IDLE; cmd_packet all ones.
- Packet layout: {1'b0, 1'b1, index[5:0], arg[31:0], crc7[6:0], 1'b1}.
- CRC7: poly x^7+x^3+1, init 0, MSB first over packet bits [47:8], one bit per clock.
- State IDLE: on cmd_start, capture index/arg/type, clear all error flags, assert busy, go to CRC_TX.
  - cmd_start while busy is ignored.
- State CRC_TX: 40 cycles feeding bits [47:8], then go to LOAD.
- State LOAD: drive cmd_packet and pulse snd_cmd_strb for exactly 1 cycle. snd_cmd_strb is high on the 42nd rising edge after the accepting edge. Go to WAIT_TX.
- State WAIT_TX:
  - On end_bit_det_strb: if resp_type==0, go to DONE; otherwise clear the timeout counter and go to WAIT_RESP.
  - If TX_WDOG elapses first: set timeout_err, go to DONE.
- State WAIT_RESP:
  - Type 1/3 accept only new_resp_packet_strb; type 2 accepts only new_r2_packet_strb. On an accepted strobe, latch the response into resp_out/resp2_out.
  - Type 1: go to CRC_RX. Types 2/3: go to CHECK.
  - When the counter reaches RESP_TIMEOUT: set timeout_err, go to DONE.
  - If the response strobe and timeout expiry fall on the same cycle, the response wins.
- State CRC_RX: 40 cycles over resp_out[47:8]; crc_err = (crc != resp_out[7:1]). Go to CHECK.
- State CHECK (1 cycle):
  - end_err = !bit0 of the latched response.
  - index_err: type 1 checks resp_out[45:40] != index; type 2 checks resp2_packet[133:128] != 6'h3F; type 3 is not checked.
  - Go to DONE.
- State DONE: done_strb=1 for 1 cycle, busy drops the next cycle, r2_resp_enb returns to 0, go to IDLE.
- Stray serializer strobes in any state other than WAIT_TX/WAIT_RESP are ignored.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No done_strb is issued for the aborted command.

Decomposition:
- Shared package `sd_pkg`:
  - RESP_NONE/RESP_48/RESP_R2/RESP_R3 constants
  - state encoding
  - CRC7 polynomial 7'h09
  - packet field positions
- One sub-module `sd_crc7`:
  - inputs: clk, reset, clear, enable, din
  - output: crc[6:0]
  - single instance, time-shared between TX and RX.

Test Plan:
- CMD0, arg 0, type 0 -> cmd_packet 0x400000000095, one snd_cmd_strb, done_strb after end_bit_det_strb, all error flags 0.
- CMD17, arg 0, type 1 -> cmd_packet 0x510000000055; response 0x110000090001 with a wrong CRC -> crc_err=1, index_err=0.
- CMD8, arg 0x1AA, type 1 -> cmd_packet 0x48000001AA87; response 0x08000001AA13 -> done, no errors, resp_out=0x08000001AA13.
- CMD8, arg 0x1AA, type 1, no response strobe -> timeout_err=1 exactly 64 cycles after end_bit_det_strb; a late response strobe is ignored.
- CMD2, type 2 -> r2_resp_enb=1 throughout; resp2_packet with [133:128]=0x3F, bit0=1 -> no errors, resp2_out=resp2_packet[127:0]; a repeat with bit0=0 -> end_err=1.
- Assert reset during WAIT_RESP -> busy=0, snd_cmd_strb=0, no done_strb. A new CMD0 afterwards completes normally.
